// File: rtl/maxpool_row_ctrl.sv
// rtl/maxpool_row_ctrl.sv - 2x2 max-pool row controller around an external horizontal max array
// Pairs input rows: the first row's even-lane results are buffered, the second is max-merged into one pooled row.
module maxpool_row_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_MODULES = 16,
  parameter int ROW_CNT_W   = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ROW_CNT_W-1:0]                  cfg_num_rows,
  output logic                                  busy,
  output logic                                  done,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH*NUM_MODULES-1:0]     in_data,
  output logic [DATA_WIDTH*NUM_MODULES-1:0]     pe_data_in,
  input  logic [DATA_WIDTH*NUM_MODULES-1:0]     pe_data_out,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH*NUM_MODULES/2-1:0]   out_data,
  output logic                                  out_last
);

  localparam int HALF = NUM_MODULES / 2;
  localparam int LH   = DATA_WIDTH * HALF;

  typedef enum logic [2:0] {IDLE, ROW_A, ROW_B, EMIT, FIN} state_t;

  state_t                 state;
  logic [ROW_CNT_W-1:0]   row_cnt;
  logic [ROW_CNT_W-1:0]   row_cnt_nxt;
  logic [ROW_CNT_W-1:0]   num_rows;
  logic [LH-1:0]          row_buf;
  logic [LH-1:0]          even_lanes;
  logic [LH-1:0]          odd_lanes;
  logic [LH-1:0]          pooled;
  logic                   odd_lanes_unused;

  assign pe_data_in  = in_data;
  assign row_cnt_nxt = row_cnt + ROW_CNT_W'(1);

  // The array leaves the pair max in the even lane; odd lanes carry nothing useful.
  for (genvar j = 0; j < HALF; j++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] buf_lane;
    logic signed [DATA_WIDTH-1:0] arr_lane;
    assign buf_lane = row_buf[j*DATA_WIDTH +: DATA_WIDTH];
    assign arr_lane = pe_data_out[2*j*DATA_WIDTH +: DATA_WIDTH];
    assign even_lanes[j*DATA_WIDTH +: DATA_WIDTH] = arr_lane;
    assign odd_lanes[j*DATA_WIDTH +: DATA_WIDTH]  = pe_data_out[(2*j+1)*DATA_WIDTH +: DATA_WIDTH];
    assign pooled[j*DATA_WIDTH +: DATA_WIDTH]     = (arr_lane > buf_lane) ? arr_lane : buf_lane;
  end

  assign odd_lanes_unused = ^odd_lanes;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      num_rows  <= '0;
      row_buf   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_rows <= cfg_num_rows;
            row_cnt  <= '0;
            busy     <= 1'b1;
            if (cfg_num_rows == '0) begin
              state <= FIN;
            end else begin
              state    <= ROW_A;
              in_ready <= 1'b1;
            end
          end
        end
        ROW_A: begin
          if (in_valid && in_ready) begin
            row_cnt <= row_cnt_nxt;
            if (row_cnt_nxt == num_rows) begin
              // Odd row count: the lone final row pools horizontally only.
              out_data  <= even_lanes;
              out_valid <= 1'b1;
              out_last  <= 1'b1;
              in_ready  <= 1'b0;
              state     <= EMIT;
            end else begin
              row_buf <= even_lanes;
              state   <= ROW_B;
            end
          end
        end
        ROW_B: begin
          if (in_valid && in_ready) begin
            row_cnt   <= row_cnt_nxt;
            out_data  <= pooled;
            out_valid <= 1'b1;
            out_last  <= (row_cnt_nxt == num_rows);
            in_ready  <= 1'b0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= FIN;
            end else begin
              state    <= ROW_A;
              in_ready <= 1'b1;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_row_ctrl.sv
// tb/tb_maxpool_row_ctrl.sv - scoreboard bench for maxpool_row_ctrl
module tb_maxpool_row_ctrl;

  localparam int DW = 16;
  localparam int NM = 16;
  localparam int RW = 10;
  localparam int L  = DW * NM;
  localparam int LH = L / 2;
  localparam int CW = LH + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RW-1:0] cfg_num_rows;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [L-1:0]  in_data;
  logic [L-1:0]  pe_data_in;
  logic [L-1:0]  pe_data_out;
  logic          out_valid;
  logic          out_ready;
  logic [LH-1:0] out_data;
  logic          out_last;

  int n_tests = 0;
  int n_fail  = 0;

  logic [LH:0]   exp_q[$];
  logic [L-1:0]  rows[$];
  logic [LH:0]   sb_e;
  logic [LH-1:0] held;
  int            bp_t;

  maxpool_row_ctrl #(.DATA_WIDTH(DW), .NUM_MODULES(NM), .ROW_CNT_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_rows(cfg_num_rows),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .pe_data_in(pe_data_in), .pe_data_out(pe_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Horizontal max array: pair max in even lanes, a poison value in odd lanes.
  function automatic logic [L-1:0] array_model(input logic [L-1:0] r);
    logic signed [DW-1:0] a, b;
    array_model = '0;
    for (int j = 0; j < NM/2; j++) begin
      a = r[2*j*DW +: DW];
      b = r[(2*j+1)*DW +: DW];
      array_model[2*j*DW +: DW]     = (a > b) ? a : b;
      array_model[(2*j+1)*DW +: DW] = 16'h7FFF;
    end
  endfunction

  assign pe_data_out = array_model(pe_data_in);

  function automatic logic [LH-1:0] pool_exp(input logic [L-1:0] r0, input logic [L-1:0] r1, input bit has_r1);
    logic signed [DW-1:0] m, v;
    pool_exp = '0;
    for (int j = 0; j < NM/2; j++) begin
      m = r0[2*j*DW +: DW];
      v = r0[(2*j+1)*DW +: DW];
      if (v > m) m = v;
      if (has_r1) begin
        v = r1[2*j*DW +: DW];
        if (v > m) m = v;
        v = r1[(2*j+1)*DW +: DW];
        if (v > m) m = v;
      end
      pool_exp[j*DW +: DW] = m;
    end
  endfunction

  task automatic check_eq(input string tag, input logic [LH:0] got, input logic [LH:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_extra_row", CW'(1), CW'(0));
      end else begin
        sb_e = exp_q.pop_front();
        check_eq("out_data", CW'(out_data), CW'(sb_e[LH-1:0]));
        check_eq("out_last", CW'(out_last), CW'(sb_e[LH]));
      end
    end
  end

  task automatic feed_row(input logic [L-1:0] row);
    int t;
    in_data  = row;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) begin
      check_eq("in_ready_timeout", CW'(0), CW'(1));
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
    end
  endtask

  task automatic run_pass(input int n);
    int t;
    for (int i = 0; i < n; i += 2)
      exp_q.push_back({(i + 2 >= n), pool_exp(rows[i], (i + 1 < n) ? rows[i+1] : '0, (i + 1 < n))});
    cfg_num_rows = RW'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) feed_row(rows[i]);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 200);
    check_eq("done_seen", CW'(done), CW'(1));
    check_eq("done_latency", CW'(t), CW'(3));
    check_eq("busy_at_done", CW'(busy), CW'(0));
    @(negedge clk);
    check_eq("done_one_cycle", CW'(done), CW'(0));
    check_eq("sb_drained", CW'(exp_q.size()), CW'(0));
  endtask

  task automatic rand_rows(input int n);
    logic [L-1:0] r;
    rows.delete();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NM; k++) r[k*DW +: DW] = DW'($urandom);
      rows.push_back(r);
    end
  endtask

  initial begin
    logic [L-1:0] r;
    int seen;
    rst = 1'b1; start = 1'b0; cfg_num_rows = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", CW'(busy), CW'(0));
    check_eq("rst_done", CW'(done), CW'(0));
    check_eq("rst_in_ready", CW'(in_ready), CW'(0));
    check_eq("rst_out_valid", CW'(out_valid), CW'(0));
    check_eq("rst_out_last", CW'(out_last), CW'(0));
    check_eq("rst_out_data", CW'(out_data), CW'(0));

    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_in_ready", CW'(in_ready), CW'(0));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    rows.delete();
    for (int k = 0; k < NM; k++) r[k*DW +: DW] = DW'(k);
    rows.push_back(r);
    for (int k = 0; k < NM; k++) r[k*DW +: DW] = DW'(15 - k);
    rows.push_back(r);
    run_pass(2);

    rows.delete();
    rows.push_back({NM{16'hFFFF}});
    rows.push_back({NM{16'h8000}});
    run_pass(2);

    rand_rows(3);
    run_pass(3);

    rand_rows(2);
    fork
      run_pass(2);
      begin
        repeat (3) @(negedge clk);
        cfg_num_rows = RW'(1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join

    rand_rows(4);
    out_ready = 1'b0;
    fork
      run_pass(4);
      begin
        bp_t = 0;
        do begin
          @(negedge clk);
          bp_t++;
        end while (!out_valid && bp_t < 200);
        check_eq("bp_valid", CW'(out_valid), CW'(1));
        held = out_data;
        repeat (5) begin
          @(negedge clk);
          check_eq("bp_valid_hold", CW'(out_valid), CW'(1));
          check_eq("bp_data_hold", CW'(out_data), CW'(held));
          check_eq("bp_in_ready", CW'(in_ready), CW'(0));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    cfg_num_rows = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_eq("cfg0_busy", CW'(busy), CW'(1));
    check_eq("cfg0_in_ready", CW'(in_ready), CW'(0));
    check_eq("cfg0_done_early", CW'(done), CW'(0));
    @(negedge clk);
    check_eq("cfg0_done", CW'(done), CW'(1));
    check_eq("cfg0_busy_fall", CW'(busy), CW'(0));
    @(posedge clk); #1;

    rand_rows(4);
    cfg_num_rows = RW'(4);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    feed_row(rows[0]);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_busy", CW'(busy), CW'(0));
    check_eq("mid_rst_in_ready", CW'(in_ready), CW'(0));
    check_eq("mid_rst_out_valid", CW'(out_valid), CW'(0));
    check_eq("mid_rst_out_last", CW'(out_last), CW'(0));
    check_eq("mid_rst_out_data", CW'(out_data), CW'(0));
    seen = 0;
    repeat (6) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check_eq("mid_rst_no_done", CW'(seen), CW'(0));
    @(posedge clk); #1;
    run_pass(4);

    rand_rows(5);
    run_pass(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
